// File: rtl/snn_ecg_classifier.sv
// ---------------------------------------------------------------------------
// snn_ecg_classifier
//
// Two-layer integrate-and-fire spiking classifier for a single ECG beat.
// 256 time-to-spike coded inputs drive 8 hidden neurons, whose spikes drive
// 6 output neurons, over NUM_STEPS time steps. Output neurons are paired
// into three classes; the pair with the most output spikes wins.
//
// Weights live in per-neuron ROMs (neuron_hidN.ROM0.mem, neuron_outN.ROM0.mem)
// and the input codes live in in_period[]; all of them are loaded from
// outside by hierarchical writes and are never touched by reset.
//
// Ports
//   clk          in   1  system clock, rising edge
//   resetn       in   1  asynchronous active-low reset
//   output_class out  2  winning class index 0..2
//   no_spike     out  1  1 = no output neuron fired during the run
//   end_process  out  1  one-cycle pulse marking the result as valid
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// SnnWeightRom
//
// Combinational-read weight store. The contents are preloaded externally.
//
// Ports
//   addr_i  in   AW  weight index
//   data_o  out  8   signed weight at addr_i
// ---------------------------------------------------------------------------
module SnnWeightRom #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic        [AW-1:0] addr_i,
   output logic signed [7:0]    data_o
);

   logic signed [7:0] mem [0:DEPTH-1];

   assign data_o = mem[addr_i];

endmodule

// ---------------------------------------------------------------------------
// SnnNeuron
//
// One integrate-and-fire neuron with a 16-bit saturating membrane and no
// leak. The controller either asks it to integrate the weight at addr_i or
// to evaluate its threshold; fire_o reports a threshold crossing during the
// evaluation cycle so the caller can latch or count it.
//
// Ports
//   clk     in   1   system clock
//   resetn  in   1   asynchronous active-low reset (clears the membrane)
//   addr_i  in   AW  synapse index for integration
//   acc_i   in   1   add weight[addr_i] to the membrane this cycle
//   fire_i  in   1   evaluate the threshold this cycle
//   fire_o  out  1   neuron fires in this evaluation cycle
// ---------------------------------------------------------------------------
module SnnNeuron #(
   parameter int                 NUM_IN = 256,
   parameter logic signed [15:0] THRESH = 16'sd64
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [$clog2(NUM_IN)-1:0] addr_i,
   input  logic                      acc_i,
   input  logic                      fire_i,
   output logic                      fire_o
);

   localparam int AW = $clog2(NUM_IN);

   logic signed [15:0] v_q;
   logic signed [15:0] v_d;
   logic signed [7:0]  weight;
   logic signed [16:0] sum;

   SnnWeightRom #(.DEPTH(NUM_IN), .AW(AW)) ROM0 (
      .addr_i (addr_i),
      .data_o (weight)
   );

   // One guard bit above the membrane catches overflow in either direction.
   assign sum    = {v_q[15], v_q} + {{9{weight[7]}}, weight};
   assign fire_o = fire_i && (v_q >= THRESH);

   // Next membrane value: reset to zero after firing, otherwise integrate
   // with clamping at the 16-bit signed limits so a long run of negative
   // weights cannot wrap round into a large positive potential.
   always_comb begin
      v_d = v_q;
      if (fire_i) begin
         if (v_q >= THRESH) begin
            v_d = '0;
         end
      end else if (acc_i) begin
         if (sum[16] != sum[15]) begin
            v_d = sum[16] ? 16'sh8000 : 16'sh7FFF;
         end else begin
            v_d = sum[15:0];
         end
      end
   end

   // Membrane register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         v_q <= '0;
      end else begin
         v_q <= v_d;
      end
   end

endmodule

// ---------------------------------------------------------------------------
// snn_ecg_classifier (chip top)
// ---------------------------------------------------------------------------
module snn_ecg_classifier #(
   parameter int                 NUM_STEPS = 64,
   parameter logic signed [15:0] TH_HID    = 16'sd64,
   parameter logic signed [15:0] TH_OUT    = 16'sd64
) (
   input  logic       clk,
   input  logic       resetn,
   output logic [1:0] output_class,
   output logic       no_spike,
   output logic       end_process
);

   typedef enum logic [2:0] {
      IDLE,
      SCAN_IN,
      FIRE_HID,
      SCAN_HID,
      FIRE_OUT,
      DECIDE,
      DONE,
      HOLD
   } state_t;

   // Input time-to-spike codes, loaded externally and never reset.
   reg [5:0] in_period [0:255];

   state_t     state_q;
   logic [5:0] stepIdx_q;
   logic [7:0] addr_q;
   logic [7:0] hidSpike_q;
   logic [5:0] outCnt_q [6];
   logic [1:0] class_q;
   logic       noSpike_q;
   logic       endProc_q;

   logic       inSpike;
   logic       hidAcc;
   logic       hidFireEn;
   logic       outAcc;
   logic       outFireEn;
   logic [7:0] hidFire;
   logic [5:0] outFire;
   logic [6:0] score [3];
   logic [1:0] bestClass;
   logic       anySpike;

   // Code 63 means "never spikes", even in the last step where t also equals 63.
   assign inSpike   = (in_period[addr_q] == stepIdx_q) && (in_period[addr_q] != 6'd63);
   assign hidAcc    = (state_q == SCAN_IN) && inSpike;
   assign hidFireEn = (state_q == FIRE_HID);
   assign outAcc    = (state_q == SCAN_HID) && hidSpike_q[addr_q[2:0]];
   assign outFireEn = (state_q == FIRE_OUT);

   SnnNeuron #(.NUM_IN(256), .THRESH(TH_HID)) neuron_hid0 (.clk(clk), .resetn(resetn), .addr_i(addr_q), .acc_i(hidAcc), .fire_i(hidFireEn), .fire_o(hidFire[0]));
   SnnNeuron #(.NUM_IN(256), .THRESH(TH_HID)) neuron_hid1 (.clk(clk), .resetn(resetn), .addr_i(addr_q), .acc_i(hidAcc), .fire_i(hidFireEn), .fire_o(hidFire[1]));
   SnnNeuron #(.NUM_IN(256), .THRESH(TH_HID)) neuron_hid2 (.clk(clk), .resetn(resetn), .addr_i(addr_q), .acc_i(hidAcc), .fire_i(hidFireEn), .fire_o(hidFire[2]));
   SnnNeuron #(.NUM_IN(256), .THRESH(TH_HID)) neuron_hid3 (.clk(clk), .resetn(resetn), .addr_i(addr_q), .acc_i(hidAcc), .fire_i(hidFireEn), .fire_o(hidFire[3]));
   SnnNeuron #(.NUM_IN(256), .THRESH(TH_HID)) neuron_hid4 (.clk(clk), .resetn(resetn), .addr_i(addr_q), .acc_i(hidAcc), .fire_i(hidFireEn), .fire_o(hidFire[4]));
   SnnNeuron #(.NUM_IN(256), .THRESH(TH_HID)) neuron_hid5 (.clk(clk), .resetn(resetn), .addr_i(addr_q), .acc_i(hidAcc), .fire_i(hidFireEn), .fire_o(hidFire[5]));
   SnnNeuron #(.NUM_IN(256), .THRESH(TH_HID)) neuron_hid6 (.clk(clk), .resetn(resetn), .addr_i(addr_q), .acc_i(hidAcc), .fire_i(hidFireEn), .fire_o(hidFire[6]));
   SnnNeuron #(.NUM_IN(256), .THRESH(TH_HID)) neuron_hid7 (.clk(clk), .resetn(resetn), .addr_i(addr_q), .acc_i(hidAcc), .fire_i(hidFireEn), .fire_o(hidFire[7]));

   SnnNeuron #(.NUM_IN(8), .THRESH(TH_OUT)) neuron_out0 (.clk(clk), .resetn(resetn), .addr_i(addr_q[2:0]), .acc_i(outAcc), .fire_i(outFireEn), .fire_o(outFire[0]));
   SnnNeuron #(.NUM_IN(8), .THRESH(TH_OUT)) neuron_out1 (.clk(clk), .resetn(resetn), .addr_i(addr_q[2:0]), .acc_i(outAcc), .fire_i(outFireEn), .fire_o(outFire[1]));
   SnnNeuron #(.NUM_IN(8), .THRESH(TH_OUT)) neuron_out2 (.clk(clk), .resetn(resetn), .addr_i(addr_q[2:0]), .acc_i(outAcc), .fire_i(outFireEn), .fire_o(outFire[2]));
   SnnNeuron #(.NUM_IN(8), .THRESH(TH_OUT)) neuron_out3 (.clk(clk), .resetn(resetn), .addr_i(addr_q[2:0]), .acc_i(outAcc), .fire_i(outFireEn), .fire_o(outFire[3]));
   SnnNeuron #(.NUM_IN(8), .THRESH(TH_OUT)) neuron_out4 (.clk(clk), .resetn(resetn), .addr_i(addr_q[2:0]), .acc_i(outAcc), .fire_i(outFireEn), .fire_o(outFire[4]));
   SnnNeuron #(.NUM_IN(8), .THRESH(TH_OUT)) neuron_out5 (.clk(clk), .resetn(resetn), .addr_i(addr_q[2:0]), .acc_i(outAcc), .fire_i(outFireEn), .fire_o(outFire[5]));

   // Class scores are the spike counts of each output pair. Scanning upward
   // with a strict greater-than leaves ties with the lower class index.
   always_comb begin
      bestClass = 2'd0;
      anySpike  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         score[k] = {1'b0, outCnt_q[2*k]} + {1'b0, outCnt_q[2*k+1]};
      end
      if (score[1] > score[0]) begin
         bestClass = 2'd1;
      end
      if ((score[2] > score[0]) && (score[2] > score[1])) begin
         bestClass = 2'd2;
      end
      for (int j = 0; j < 6; j++) begin
         if (outCnt_q[j] != 6'd0) begin
            anySpike = 1'b1;
         end
      end
   end

   // Sequencer. Each time step is a 256-cycle input scan, one hidden fire
   // cycle, an 8-cycle hidden-spike scan and one output fire cycle. Hidden
   // spike bits are latched in FIRE_HID and consumed in the following scan;
   // output spikes are counted directly in FIRE_OUT. After the last step the
   // result is latched in DECIDE and end_process is raised for the DONE cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         stepIdx_q  <= '0;
         addr_q     <= '0;
         hidSpike_q <= '0;
         class_q    <= '0;
         noSpike_q  <= 1'b0;
         endProc_q  <= 1'b0;
         for (int j = 0; j < 6; j++) begin
            outCnt_q[j] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               addr_q  <= '0;
               state_q <= SCAN_IN;
            end
            SCAN_IN: begin
               if (addr_q == 8'd255) begin
                  addr_q  <= '0;
                  state_q <= FIRE_HID;
               end else begin
                  addr_q <= addr_q + 8'd1;
               end
            end
            FIRE_HID: begin
               hidSpike_q <= hidFire;
               addr_q     <= '0;
               state_q    <= SCAN_HID;
            end
            SCAN_HID: begin
               if (addr_q == 8'd7) begin
                  addr_q  <= '0;
                  state_q <= FIRE_OUT;
               end else begin
                  addr_q <= addr_q + 8'd1;
               end
            end
            FIRE_OUT: begin
               for (int j = 0; j < 6; j++) begin
                  if (outFire[j] && (outCnt_q[j] != 6'd63)) begin
                     outCnt_q[j] <= outCnt_q[j] + 6'd1;
                  end
               end
               if (stepIdx_q == 6'(NUM_STEPS - 1)) begin
                  state_q <= DECIDE;
               end else begin
                  stepIdx_q <= stepIdx_q + 6'd1;
                  state_q   <= SCAN_IN;
               end
            end
            DECIDE: begin
               class_q   <= anySpike ? bestClass : 2'd0;
               noSpike_q <= ~anySpike;
               endProc_q <= 1'b1;
               state_q   <= DONE;
            end
            DONE: begin
               endProc_q <= 1'b0;
               state_q   <= HOLD;
            end
            default: begin
               endProc_q <= 1'b0;
               state_q   <= HOLD;
            end
         endcase
      end
   end

   assign output_class = class_q;
   assign no_spike     = noSpike_q;
   assign end_process  = endProc_q;

endmodule

// File: tb/tb_snn_ecg_classifier.sv
// ---------------------------------------------------------------------------
// tb_snn_ecg_classifier
//
// Self-checking bench for snn_ecg_classifier. Weights and input codes are
// preloaded by hierarchical writes while reset is held; expected results come
// from directed constants or from a step-by-step behavioural model of the
// classifier written with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_snn_ecg_classifier;

   // Rising edges counted from the release of reset up to the edge that
   // raises end_process (the pulse occupies the 17027th cycle).
   localparam int LATENCY    = 17026;
   localparam int WAIT_LIMIT = 20000;

   logic       clk    = 1'b0;
   logic       resetn = 1'b1;
   logic [1:0] output_class;
   logic       no_spike;
   logic       end_process;

   int compared   = 0;
   int mismatched = 0;

   int hidW [8][256];
   int outW [6][8];
   int inP  [256];

   snn_ecg_classifier dut (
      .clk          (clk),
      .resetn       (resetn),
      .output_class (output_class),
      .no_spike     (no_spike),
      .end_process  (end_process)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Hierarchical weight writes; instance names cannot be indexed, so dispatch by number.
   task automatic setHidW(input int n, input int a, input logic [7:0] w);
      case (n)
         0: dut.neuron_hid0.ROM0.mem[a] = w;
         1: dut.neuron_hid1.ROM0.mem[a] = w;
         2: dut.neuron_hid2.ROM0.mem[a] = w;
         3: dut.neuron_hid3.ROM0.mem[a] = w;
         4: dut.neuron_hid4.ROM0.mem[a] = w;
         5: dut.neuron_hid5.ROM0.mem[a] = w;
         6: dut.neuron_hid6.ROM0.mem[a] = w;
         default: dut.neuron_hid7.ROM0.mem[a] = w;
      endcase
   endtask

   task automatic setOutW(input int n, input int a, input logic [7:0] w);
      case (n)
         0: dut.neuron_out0.ROM0.mem[a] = w;
         1: dut.neuron_out1.ROM0.mem[a] = w;
         2: dut.neuron_out2.ROM0.mem[a] = w;
         3: dut.neuron_out3.ROM0.mem[a] = w;
         4: dut.neuron_out4.ROM0.mem[a] = w;
         default: dut.neuron_out5.ROM0.mem[a] = w;
      endcase
   endtask

   // Zero weights, all inputs silent.
   task automatic clearConfig();
      for (int i = 0; i < 256; i++) begin
         inP[i] = 63;
         for (int h = 0; h < 8; h++) hidW[h][i] = 0;
      end
      for (int o = 0; o < 6; o++)
         for (int h = 0; h < 8; h++) outW[o][h] = 0;
   endtask

   task automatic loadConfig();
      for (int i = 0; i < 256; i++) begin
         dut.in_period[i] = 6'(inP[i]);
         for (int h = 0; h < 8; h++) setHidW(h, i, 8'(hidW[h][i]));
      end
      for (int o = 0; o < 6; o++)
         for (int h = 0; h < 8; h++) setOutW(o, h, 8'(outW[o][h]));
   endtask

   // Hold reset, preload, then release on a falling edge.
   task automatic applyStimulus();
      @(negedge clk);
      resetn = 1'b0;
      loadConfig();
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   // Count rising edges until end_process is seen high on a falling edge.
   task automatic waitForEnd(output int cycles, output bit seen);
      cycles = 0;
      seen   = 1'b0;
      while (!seen && (cycles < WAIT_LIMIT)) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
         if (end_process === 1'b1) seen = 1'b1;
      end
   endtask

   function automatic int sat16(input int x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   // Behavioural reference: one full classification from the current arrays.
   task automatic runModel(output logic [1:0] cls, output logic ns);
      int vh [8];
      int vo [6];
      int cnt [6];
      bit hs [8];
      int sc [3];
      int best;
      for (int h = 0; h < 8; h++) vh[h] = 0;
      for (int o = 0; o < 6; o++) begin
         vo[o]  = 0;
         cnt[o] = 0;
      end
      for (int t = 0; t < 64; t++) begin
         for (int i = 0; i < 256; i++)
            if ((inP[i] == t) && (inP[i] != 63))
               for (int h = 0; h < 8; h++) vh[h] = sat16(vh[h] + hidW[h][i]);
         for (int h = 0; h < 8; h++) begin
            hs[h] = (vh[h] >= 64);
            if (hs[h]) vh[h] = 0;
         end
         for (int h = 0; h < 8; h++)
            if (hs[h])
               for (int o = 0; o < 6; o++) vo[o] = sat16(vo[o] + outW[o][h]);
         for (int o = 0; o < 6; o++)
            if (vo[o] >= 64) begin
               vo[o] = 0;
               if (cnt[o] < 63) cnt[o]++;
            end
      end
      best = 0;
      for (int k = 0; k < 3; k++) sc[k] = cnt[2*k] + cnt[2*k+1];
      for (int k = 1; k < 3; k++) if (sc[k] > sc[best]) best = k;
      ns  = ((sc[0] + sc[1] + sc[2]) == 0);
      cls = ns ? 2'd0 : 2'(best);
   endtask

   // Reset asserted before the first clock edge clears every output.
   task automatic test_reset();
      $display("[TB] test_reset");
      #3 resetn = 1'b0;
      #1;
      compared++;
      if (output_class !== 2'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_class: got %0d, expected 0", output_class);
      end
      compared++;
      if (no_spike !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_no_spike: got %b, expected 0", no_spike);
      end
      repeat (3) @(negedge clk);
      compared++;
      if (end_process !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_end_process: got %b, expected 0", end_process);
      end
   endtask

   // All inputs silent with random weights: a single pulse, no_spike=1, class 0.
   task automatic test_all_silent();
      int  cyc;
      bit  seen;
      int  highs;
      $display("[TB] test_all_silent");
      clearConfig();
      for (int i = 0; i < 256; i++)
         for (int h = 0; h < 8; h++) hidW[h][i] = int'($urandom_range(0, 255)) - 128;
      for (int o = 0; o < 6; o++)
         for (int h = 0; h < 8; h++) outW[o][h] = int'($urandom_range(0, 255)) - 128;
      applyStimulus();
      waitForEnd(cyc, seen);
      compared++;
      if (!seen || (cyc != LATENCY)) begin
         mismatched++;
         $display("[TB] FAIL silent_latency: seen=%0b after %0d edges, expected pulse after %0d", seen, cyc, LATENCY);
      end
      compared++;
      if (no_spike !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL silent_no_spike: got %b, expected 1", no_spike);
      end
      compared++;
      if (output_class !== 2'd0) begin
         mismatched++;
         $display("[TB] FAIL silent_class: got %0d, expected 0", output_class);
      end
      highs = 0;
      repeat (4) begin
         @(negedge clk);
         if (end_process !== 1'b0) highs++;
      end
      compared++;
      if (highs != 0) begin
         mismatched++;
         $display("[TB] FAIL silent_pulse_width: end_process high on %0d later cycles, expected 0", highs);
      end
      compared++;
      if ((output_class !== 2'd0) || (no_spike !== 1'b1)) begin
         mismatched++;
         $display("[TB] FAIL silent_hold: class=%0d no_spike=%b, expected 0/1", output_class, no_spike);
      end
   endtask

   // One input at t=0 drives hid0 then out2: class 1. Reset during the pulse clears outputs at once.
   task automatic test_single_path();
      int cyc;
      bit seen;
      $display("[TB] test_single_path");
      clearConfig();
      inP[0]     = 0;
      hidW[0][0] = 64;
      outW[2][0] = 64;
      applyStimulus();
      waitForEnd(cyc, seen);
      compared++;
      if (!seen || (cyc != LATENCY)) begin
         mismatched++;
         $display("[TB] FAIL path_latency: seen=%0b after %0d edges, expected pulse after %0d", seen, cyc, LATENCY);
      end
      compared++;
      if (output_class !== 2'd1) begin
         mismatched++;
         $display("[TB] FAIL path_class: got %0d, expected 1", output_class);
      end
      compared++;
      if (no_spike !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL path_no_spike: got %b, expected 0", no_spike);
      end
      resetn = 1'b0;
      #1;
      compared++;
      if ((end_process !== 1'b0) || (output_class !== 2'd0) || (no_spike !== 1'b0)) begin
         mismatched++;
         $display("[TB] FAIL async_reset: end=%b class=%0d no_spike=%b, expected 0/0/0", end_process, output_class, no_spike);
      end
   endtask

   // hid0 sees -128 on every input at t=0 (exactly -32768) and once more at t=1,
   // which must clamp rather than wrap. hid1 fires at t=0 and t=1, feeding out0
   // and out4 equally, so classes 0 and 2 tie and class 0 wins. A wrapped hid0
   // would fire into out5 and tip the result to class 2.
   task automatic test_saturation_tie();
      int cyc;
      bit seen;
      $display("[TB] test_saturation_tie");
      clearConfig();
      for (int i = 0; i < 256; i++) begin
         inP[i]     = 0;
         hidW[0][i] = -128;
      end
      hidW[1][0] = 64;
      outW[0][1] = 64;
      outW[4][1] = 64;
      outW[5][0] = 64;
      applyStimulus();
      // Step 0 input scan is over after edge 257; step 1 starts reading at edge 268.
      repeat (262) begin
         @(posedge clk);
         @(negedge clk);
      end
      dut.in_period[0] = 6'd1;
      for (int i = 1; i < 256; i++) dut.in_period[i] = 6'd63;
      waitForEnd(cyc, seen);
      cyc += 262;
      compared++;
      if (!seen || (cyc != LATENCY)) begin
         mismatched++;
         $display("[TB] FAIL sat_latency: seen=%0b after %0d edges, expected pulse after %0d", seen, cyc, LATENCY);
      end
      compared++;
      if (output_class !== 2'd0) begin
         mismatched++;
         $display("[TB] FAIL sat_tie_class: got %0d, expected 0", output_class);
      end
      compared++;
      if (no_spike !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL sat_no_spike: got %b, expected 0", no_spike);
      end
   endtask

   // Random network aborted by reset at cycle 5000, then rerun to completion.
   task automatic test_abort_restart();
      logic [1:0] expCls;
      logic       expNs;
      int         cyc;
      bit         seen;
      int         early;
      $display("[TB] test_abort_restart");
      clearConfig();
      for (int i = 0; i < 256; i++) begin
         inP[i] = int'($urandom_range(0, 63));
         for (int h = 0; h < 8; h++) hidW[h][i] = int'($urandom_range(0, 200)) - 90;
      end
      for (int o = 0; o < 6; o++)
         for (int h = 0; h < 8; h++) outW[o][h] = int'($urandom_range(0, 200)) - 100;
      runModel(expCls, expNs);
      $display("[TB] model expects class=%0d no_spike=%0b", expCls, expNs);
      applyStimulus();
      early = 0;
      repeat (5000) begin
         @(posedge clk);
         @(negedge clk);
         if (end_process !== 1'b0) early++;
      end
      compared++;
      if (early != 0) begin
         mismatched++;
         $display("[TB] FAIL abort_early_pulse: end_process high on %0d cycles, expected 0", early);
      end
      resetn = 1'b0;
      #1;
      compared++;
      if ((end_process !== 1'b0) || (output_class !== 2'd0) || (no_spike !== 1'b0)) begin
         mismatched++;
         $display("[TB] FAIL abort_reset: end=%b class=%0d no_spike=%b, expected 0/0/0", end_process, output_class, no_spike);
      end
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      waitForEnd(cyc, seen);
      compared++;
      if (!seen || (cyc != LATENCY)) begin
         mismatched++;
         $display("[TB] FAIL restart_latency: seen=%0b after %0d edges, expected pulse after %0d", seen, cyc, LATENCY);
      end
      compared++;
      if (output_class !== expCls) begin
         mismatched++;
         $display("[TB] FAIL restart_class: got %0d, expected %0d", output_class, expCls);
      end
      compared++;
      if (no_spike !== expNs) begin
         mismatched++;
         $display("[TB] FAIL restart_no_spike: got %b, expected %b", no_spike, expNs);
      end
   endtask

   // Scenario sequence.
   initial begin
      test_reset();
      test_all_silent();
      test_single_path();
      test_saturation_tie();
      test_abort_restart();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
